// File: rtl/kgp_pkg.sv
// ----------------------------------------------------------------------------
// kgp_pkg
// Shared definitions for the pipeline: datapath and register-file widths,
// opcode constants, instruction field bit positions, the ID/EX record type
// and a sign-extension helper.
// No ports (package).
// ----------------------------------------------------------------------------
package kgp_pkg;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    // Opcodes. Load word is the only load class.
    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_LD  = 6'b100000;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS_HI  = 20;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic          valid;
        logic [5:0]    opcode;
        logic [AW-1:0] rd;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
        logic [DW-1:0] imm;
        logic [DW-1:0] npc;
        logic          is_load;
    } idex_t;

    // Sign-extend a 16-bit immediate to the datapath width
    function automatic logic [DW-1:0] sign_ext16(input logic [15:0] v);
        return {{(DW-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// ----------------------------------------------------------------------------
// instr_decode_stage_if
// Bundles the ID stage's fetch-side inputs, write-back port, flush, the
// stall return path and the ID/EX outputs.
//   slave  : the decode stage (consumes fetch/WB/flush, drives stall/ex_*)
//   master : the environment (drives fetch/WB/flush, observes stall/ex_*)
// ----------------------------------------------------------------------------
interface instr_decode_stage_if;
    import kgp_pkg::*;

    logic [DW-1:0] if_instr;
    logic [DW-1:0] if_NPC;
    logic          flush;
    logic          wb_we;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          stall;
    logic          ex_valid;
    logic [5:0]    ex_opcode;
    logic [AW-1:0] ex_rd;
    logic [DW-1:0] ex_rs_val;
    logic [DW-1:0] ex_rt_val;
    logic [DW-1:0] ex_imm;
    logic [DW-1:0] ex_NPC;
    logic          ex_is_load;

    modport slave (
        input  if_instr, if_NPC, flush, wb_we, wb_rd, wb_data,
        output stall, ex_valid, ex_opcode, ex_rd, ex_rs_val, ex_rt_val,
               ex_imm, ex_NPC, ex_is_load
    );

    modport master (
        output if_instr, if_NPC, flush, wb_we, wb_rd, wb_data,
        input  stall, ex_valid, ex_opcode, ex_rd, ex_rs_val, ex_rt_val,
               ex_imm, ex_NPC, ex_is_load
    );

endinterface

// File: rtl/instr_decode_stage_reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// 32 x 32 register file, two combinational read ports and one write port.
// r0 always reads zero and ignores writes. A read of the register being
// written in the same cycle returns the incoming write data.
//   clk, rst          clock, synchronous active-high reset (clears all entries)
//   we/waddr/wdata    write port, committed on the rising edge
//   raddr_a/rdata_a   read port A
//   raddr_b/rdata_b   read port B
// ----------------------------------------------------------------------------
module reg_file
    import kgp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem_r [NREG];

    // Storage: cleared on reset, written on the edge when enabled (never r0)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (we && (waddr != {AW{1'b0}})) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port A: r0 is hard zero, then write-through bypass, then storage
    always_comb begin
        rdata_a = {DW{1'b0}};
        if (raddr_a == {AW{1'b0}}) begin
            rdata_a = {DW{1'b0}};
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem_r[raddr_a];
        end
    end

    // Read port B: same priority as port A
    always_comb begin
        rdata_b = {DW{1'b0}};
        if (raddr_b == {AW{1'b0}}) begin
            rdata_b = {DW{1'b0}};
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem_r[raddr_b];
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// ----------------------------------------------------------------------------
// instr_decode_stage
// Instruction decode stage: splits the fetched instruction into fields,
// reads rs/rt from the register file, detects load-use hazards against the
// instruction currently in ID/EX, and registers the result into ID/EX.
//   clk   system clock, rising edge
//   rst   synchronous active-high reset (clears ID/EX and the register file)
//   bus   slave side of instr_decode_stage_if:
//         in : if_instr, if_NPC, flush, wb_we, wb_rd, wb_data
//         out: stall (combinational), ex_* (registered ID/EX contents)
// ----------------------------------------------------------------------------
module instr_decode_stage
    import kgp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    instr_decode_stage_if.slave   bus
);

    logic [5:0]    opcode_s;
    logic [AW-1:0] rd_s;
    logic [AW-1:0] rs_s;
    logic [AW-1:0] rt_s;
    logic [DW-1:0] imm_s;
    logic [DW-1:0] rs_val_s;
    logic [DW-1:0] rt_val_s;
    logic          stall_s;
    idex_t         ex_next_s;
    idex_t         ex_r;

    // Field extraction from the instruction presented by fetch
    always_comb begin
        opcode_s = bus.if_instr[OPC_HI:OPC_LO];
        rd_s     = bus.if_instr[RD_HI:RD_LO];
        rs_s     = bus.if_instr[RS_HI:RS_LO];
        rt_s     = bus.if_instr[RT_HI:RT_LO];
        imm_s    = sign_ext16(bus.if_instr[IMM_HI:IMM_LO]);
    end

    reg_file u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wb_we),
        .waddr   (bus.wb_rd),
        .wdata   (bus.wb_data),
        .raddr_a (rs_s),
        .raddr_b (rt_s),
        .rdata_a (rs_val_s),
        .rdata_b (rt_val_s)
    );

    // Load-use hazard: the load in ID/EX has not produced its data yet.
    // A load to r0 never stalls, and a flush squashes the consumer anyway.
    always_comb begin
        stall_s = 1'b0;
        if (ex_r.valid && ex_r.is_load && (ex_r.rd != {AW{1'b0}}) &&
            ((ex_r.rd == rs_s) || (ex_r.rd == rt_s)) && !bus.flush) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next ID/EX contents: bubble on flush or stall, decoded fields otherwise
    always_comb begin
        ex_next_s = '0;
        if (bus.flush || stall_s) begin
            ex_next_s = '0;
        end else begin
            ex_next_s.valid   = 1'b1;
            ex_next_s.opcode  = opcode_s;
            ex_next_s.rd      = rd_s;
            ex_next_s.rs_val  = rs_val_s;
            ex_next_s.rt_val  = rt_val_s;
            ex_next_s.imm     = imm_s;
            ex_next_s.npc     = bus.if_NPC;
            ex_next_s.is_load = (opcode_s == OP_LD);
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r <= '0;
        end else begin
            ex_r <= ex_next_s;
        end
    end

    assign bus.stall      = stall_s;
    assign bus.ex_valid   = ex_r.valid;
    assign bus.ex_opcode  = ex_r.opcode;
    assign bus.ex_rd      = ex_r.rd;
    assign bus.ex_rs_val  = ex_r.rs_val;
    assign bus.ex_rt_val  = ex_r.rt_val;
    assign bus.ex_imm     = ex_r.imm;
    assign bus.ex_NPC     = ex_r.npc;
    assign bus.ex_is_load = ex_r.is_load;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_instr_decode_stage
// Self-checking bench for instr_decode_stage. Each driven instruction pushes
// the expected ID/EX record (from an independent register/pipeline model)
// into a queue; a monitor pops and compares it one edge later. Scenario
// tasks additionally check stall and specific fields inline.
// ----------------------------------------------------------------------------
module tb_instr_decode_stage;

    localparam logic [5:0] T_OP_LD  = 6'b100000;
    localparam logic [5:0] T_OP_ADD = 6'b000001;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] npc;
        logic        is_load;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_decode_stage_if bus ();

    instr_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_regs [32];
    exp_t        m_ex;
    exp_t        m_next;
    exp_t        mon_exp;
    exp_t        mon_act;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] lo);
        return {op, rd, rs, lo};
    endfunction

    // Drive one instruction, predict stall and the next ID/EX record
    task automatic apply(input logic [31:0] instr, input logic [31:0] npc,
                         input logic fl, input logic we, input logic [4:0] wrd,
                         input logic [31:0] wdata, output logic exp_stall);
        logic [4:0] rs;
        logic [4:0] rt;
        logic [31:0] rsv;
        logic [31:0] rtv;
        bus.if_instr = instr;
        bus.if_NPC   = npc;
        bus.flush    = fl;
        bus.wb_we    = we;
        bus.wb_rd    = wrd;
        bus.wb_data  = wdata;
        rs = instr[20:16];
        rt = instr[15:11];
        rsv = (rs == 5'd0) ? 32'd0 : ((we && wrd == rs) ? wdata : m_regs[rs]);
        rtv = (rt == 5'd0) ? 32'd0 : ((we && wrd == rt) ? wdata : m_regs[rt]);
        exp_stall = m_ex.valid && (m_ex.opcode == T_OP_LD) && (m_ex.rd != 5'd0) &&
                    ((m_ex.rd == rs) || (m_ex.rd == rt)) && !fl;
        if (fl || exp_stall) begin
            m_next = '0;
        end else begin
            m_next.valid   = 1'b1;
            m_next.opcode  = instr[31:26];
            m_next.rd      = instr[25:21];
            m_next.rs_val  = rsv;
            m_next.rt_val  = rtv;
            m_next.imm     = {{16{instr[15]}}, instr[15:0]};
            m_next.npc     = npc;
            m_next.is_load = (instr[31:26] == T_OP_LD);
        end
        sb_q.push_back(m_next);
        if (we && wrd != 5'd0) m_regs[wrd] = wdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        m_ex = m_next;
    endtask

    // Scoreboard monitor: one expected record per clock edge after a push
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_act.valid   = bus.ex_valid;
            mon_act.opcode  = bus.ex_opcode;
            mon_act.rd      = bus.ex_rd;
            mon_act.rs_val  = bus.ex_rs_val;
            mon_act.rt_val  = bus.ex_rt_val;
            mon_act.imm     = bus.ex_imm;
            mon_act.npc     = bus.ex_NPC;
            mon_act.is_load = bus.ex_is_load;
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL scoreboard_idex: actual=%h required=%h", mon_act, mon_exp);
            end
        end
    end

    task automatic test_reset();
        logic s;
        rst = 1'b1;
        bus.if_instr = mk(T_OP_LD, 5'd4, 5'd5, 16'h2800);
        bus.if_NPC   = 32'h1234;
        bus.flush    = 1'b1;
        bus.wb_we    = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_data  = 32'hCAFEF00D;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_next = '0;
        tick();
        tick();
        n_checks++;
        if ({bus.ex_valid, bus.ex_opcode, bus.ex_rd, bus.ex_rs_val, bus.ex_rt_val,
             bus.ex_imm, bus.ex_NPC, bus.ex_is_load} !== 150'd0) begin
            n_fail++;
            $display("FAIL reset_ex: actual valid=%b npc=%h imm=%h required all zero",
                     bus.ex_valid, bus.ex_NPC, bus.ex_imm);
        end
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: actual=%b required=0", bus.stall);
        end
        rst = 1'b0;
        apply(mk(T_OP_ADD, 5'd2, 5'd5, {5'd5, 11'd0}), 32'h4, 1'b0, 1'b0, 5'd0, 32'd0, s);
        tick();
        n_checks++;
        if (bus.ex_rs_val !== 32'd0 || bus.ex_rt_val !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_r5_read: actual rs=%h rt=%h required 0", bus.ex_rs_val, bus.ex_rt_val);
        end
    endtask

    task automatic test_write_through();
        logic s;
        apply(mk(T_OP_ADD, 5'd2, 5'd3, 16'd0), 32'h8, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, s);
        tick();
        n_checks++;
        if (bus.ex_rs_val !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_through_rs: actual=%h required=deadbeef", bus.ex_rs_val);
        end
        apply(mk(T_OP_ADD, 5'd2, 5'd0, {5'd3, 11'd0}), 32'hC, 1'b0, 1'b0, 5'd0, 32'd0, s);
        tick();
        n_checks++;
        if (bus.ex_rt_val !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL stored_rt: actual=%h required=deadbeef", bus.ex_rt_val);
        end
    endtask

    task automatic test_load_use();
        logic s;
        apply(mk(T_OP_ADD, 5'd1, 5'd0, 16'd0), 32'h10, 1'b0, 1'b1, 5'd7, 32'h00001234, s);
        tick();
        apply(mk(T_OP_LD, 5'd7, 5'd1, 16'h0004), 32'h14, 1'b0, 1'b0, 5'd0, 32'd0, s);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_issue_stall: actual=%b required=0", bus.stall);
        end
        tick();
        apply(mk(T_OP_ADD, 5'd8, 5'd2, {5'd7, 11'd0}), 32'h18, 1'b0, 1'b0, 5'd0, 32'd0, s);
        n_checks++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall: actual=%b required=1", bus.stall);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_bubble: actual valid=%b required=0", bus.ex_valid);
        end
        apply(mk(T_OP_ADD, 5'd8, 5'd2, {5'd7, 11'd0}), 32'h18, 1'b0, 1'b0, 5'd0, 32'd0, s);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_one_cycle: actual=%b required=0", bus.stall);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rt_val !== 32'h00001234) begin
            n_fail++;
            $display("FAIL consumer_issue: actual valid=%b rt=%h required valid=1 rt=00001234",
                     bus.ex_valid, bus.ex_rt_val);
        end
    endtask

    task automatic test_load_r0();
        logic s;
        apply(mk(T_OP_LD, 5'd0, 5'd1, 16'd0), 32'h20, 1'b0, 1'b0, 5'd0, 32'd0, s);
        tick();
        apply(mk(T_OP_ADD, 5'd9, 5'd0, 16'd0), 32'h24, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, s);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_r0_stall: actual=%b required=0", bus.stall);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs_val !== 32'd0 || bus.ex_rt_val !== 32'd0) begin
            n_fail++;
            $display("FAIL r0_reads_zero: actual valid=%b rs=%h rt=%h required 1/0/0",
                     bus.ex_valid, bus.ex_rs_val, bus.ex_rt_val);
        end
        // A NOP right after a real load never stalls
        apply(mk(T_OP_LD, 5'd7, 5'd0, 16'd0), 32'h28, 1'b0, 1'b0, 5'd0, 32'd0, s);
        tick();
        apply(32'h0, 32'h2C, 1'b0, 1'b0, 5'd0, 32'd0, s);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_stall: actual=%b required=0", bus.stall);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== 6'd0) begin
            n_fail++;
            $display("FAIL nop_issue: actual valid=%b op=%h required 1/00", bus.ex_valid, bus.ex_opcode);
        end
    endtask

    task automatic test_flush();
        logic s;
        apply(mk(T_OP_LD, 5'd9, 5'd0, 16'd0), 32'h30, 1'b0, 1'b0, 5'd0, 32'd0, s);
        tick();
        apply(mk(T_OP_ADD, 5'd1, 5'd9, 16'd0), 32'h34, 1'b1, 1'b0, 5'd0, 32'd0, s);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: actual=%b required=0", bus.stall);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_bubble: actual valid=%b required=0", bus.ex_valid);
        end
        apply(mk(T_OP_ADD, 5'd1, 5'd2, 16'h0055), 32'h38, 1'b1, 1'b0, 5'd0, 32'd0, s);
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_imm !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_plain: actual valid=%b imm=%h required 0/0", bus.ex_valid, bus.ex_imm);
        end
    endtask

    task automatic test_imm_npc();
        logic s;
        apply(mk(6'h02, 5'd1, 5'd0, 16'h8001), 32'h40, 1'b0, 1'b0, 5'd0, 32'd0, s);
        tick();
        n_checks++;
        if (bus.ex_imm !== 32'hFFFF8001 || bus.ex_NPC !== 32'h40) begin
            n_fail++;
            $display("FAIL imm_neg_npc: actual imm=%h npc=%h required ffff8001/00000040",
                     bus.ex_imm, bus.ex_NPC);
        end
        apply(mk(6'h02, 5'd1, 5'd0, 16'h7FFF), 32'h44, 1'b0, 1'b0, 5'd0, 32'd0, s);
        tick();
        n_checks++;
        if (bus.ex_imm !== 32'h00007FFF) begin
            n_fail++;
            $display("FAIL imm_pos: actual=%h required=00007fff", bus.ex_imm);
        end
    endtask

    task automatic test_back_to_back();
        logic        s;
        logic        hold;
        logic [31:0] instr;
        logic [31:0] npc;
        hold  = 1'b0;
        npc   = 32'h100;
        instr = 32'h0;
        for (int i = 0; i < 80; i++) begin
            if (!hold) begin
                instr = mk(($urandom_range(0, 2) == 0) ? T_OP_LD : 6'($urandom_range(1, 5)),
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           {2'b00, 3'($urandom_range(0, 7)), 11'($urandom)});
                npc = npc + 32'd4;
            end
            apply(instr, npc, ($urandom_range(0, 7) == 0), 1'($urandom),
                  5'($urandom_range(0, 7)), 32'($urandom), s);
            n_checks++;
            if (bus.stall !== s) begin
                n_fail++;
                $display("FAIL b2b_stall[%0d]: actual=%b required=%b", i, bus.stall, s);
            end
            hold = s;
            tick();
        end
    endtask

    initial begin
        bus.if_instr = 32'd0;
        bus.if_NPC   = 32'd0;
        bus.flush    = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'd0;
        rst          = 1'b1;
        m_ex         = '0;
        m_next       = '0;
        test_reset();
        test_write_through();
        test_load_use();
        test_load_r0();
        test_flush();
        test_imm_npc();
        test_back_to_back();
        bus.wb_we = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d entries left required=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
